sram_dual_sync_be: RTL and testbench
====================================

// Module: sram_dual_sync_be
// PURPOSE
//  Single-clock true-dual-port synchronous RAM, generalised successor of the dual-port sync RAM.
//  Adds byte-lane write enables, selectable read latency, read-valid strobes, port-0-priority write collision handling
//  and a hardware clear sequencer. Used for tile/sprite/work RAMs that must start from a known value without an init file.
// PARAMETERS
//  DATA_WIDTH     8   word width; must be a multiple of LANE_WIDTH
//  ADDR_WIDTH     10  depth = 2**ADDR_WIDTH words; ADDR_WIDTH >= 1
//  LANE_WIDTH     8   bits per write-enable lane; LANES = DATA_WIDTH/LANE_WIDTH
//  RD_LATENCY     1   1 or 2 cycles from accepted read to Q/rvalid
//  CLEAR_ON_RESET 1   1: clear sequence starts automatically on reset release
//  CLEAR_VALUE    0   word written to every location by the clear sequence
// PORTS
//  clk      in  1          single clock, all logic on posedge
//  reset_n  in  1          synchronous, active-low reset
//  clr_req  in  1          pulse in IDLE starts a clear sequence; ignored while busy
//  busy     out 1          1 while clearing; user accesses are ignored
//  clr_done out 1          1-cycle pulse on the cycle after the last clear write
//  wr_coll  out 1          1-cycle pulse: both ports wrote the same address in the same cycle
//  cen0     in  1          port-0 access enable
//  we0      in  1          port-0 write (qualified by cen0)
//  be0      in  LANES      port-0 lane enables for writes
//  ADDR0    in  ADDR_WIDTH port-0 address
//  DATA0    in  DATA_WIDTH port-0 write data
//  Q0       out DATA_WIDTH port-0 read data
//  rvalid0  out 1          port-0 Q0 valid strobe
//  cen1/we1/be1/ADDR1/DATA1/Q1/rvalid1  port 1, same as port 0
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - Q0/Q1=0; rvalid*, clr_done, wr_coll = 0; clear counter = 0.
//   - state = CLEAR if CLEAR_ON_RESET, else IDLE; busy = CLEAR_ON_RESET.
//   - Memory contents are not reset. Reset during CLEAR restarts the clear from address 0.
//  FSM IDLE -> CLEAR (reset release with CLEAR_ON_RESET, or clr_req in IDLE) -> DONE (1 cycle, clr_done=1) -> IDLE.
//  CLEAR:
//   - Each cycle port 0 writes CLEAR_VALUE at {cnt,0} and port 1 at {cnt,1}; all lanes written.
//   - Takes 2**(ADDR_WIDTH-1) cycles; busy=1 from the first to the last clear write.
//   - User cen/we are ignored; rvalid stays 0.
//  Access (IDLE/DONE), per port p, cen_p=1 at edge N:
//   - Read of ADDR_p issued at edge N.
//   - RD_LATENCY=1: Q_p/rvalid_p valid after edge N. RD_LATENCY=2: valid after edge N+1.
//   - Full pipeline: one access per cycle per port, no stalls.
//   - rvalid_p=1 for reads and writes alike; Q_p holds its last value when rvalid_p=0.
//   - we_p=1: lanes with be_p[i]=1 take DATA_p[i*LANE_WIDTH +: LANE_WIDTH]; other lanes are unchanged. be_p=0 is a no-op write.
//  Collision, both ports write the same address in the same cycle:
//   - Port 0 wins the whole word; port-1 write suppressed; wr_coll=1 on the next cycle.
//   - Reads never collide.
//  Read-during-write: see CONFIGURATION. Address wrap is natural modulo 2**ADDR_WIDTH.
// CONFIGURATION
//  SRAM_WR_BYPASS_EN defined:
//   - Write-first: a read returns the merged new word when the same cycle writes that address on the same port,
//     or on the other port (port-0 data has priority).
//  SRAM_WR_BYPASS_EN undefined:
//   - Read-first: the read returns the old word; RAM inferable with no_rw_check.
// STRUCTURE
//  Package sram_pkg:
//   - Clear-FSM state localparams (IDLE, CLEAR, DONE).
//   - Function lanes(DATA_WIDTH, LANE_WIDTH).
//   - Lane-merge function merge(old, new, be).
//  Sub-module sram_clear_seq:
//   - FSM, clear counter, busy/clr_done generation.
//   - Drives the clear address/write overrides muxed into both ports.
//  Top level: memory array, lane-masked writes, collision suppress, bypass (macro), RD_LATENCY output stage.
// TESTING
//  1. Reset, CLEAR_ON_RESET=1, ADDR_WIDTH=4, CLEAR_VALUE=8'hA5 -> busy=1 for 8 cycles, clr_done pulse,
//     then reads of 0..15 all return A5.
//  2. Port 0: write 16'h1234 be=2'b11 @3, then 16'hABCD be=2'b01 @3; read @3 -> Q0=16'h12CD,
//     rvalid0 after 1 cycle (RD_LATENCY=1) / 2 cycles (RD_LATENCY=2).
//  3. Same cycle: port 0 writes 8'h11 @5, port 1 writes 8'h22 @5 -> wr_coll pulse; later read @5 = 8'h11.
//  4. Port 0 writes 8'h77 @9 while port 1 reads @9 (old 8'h00) -> Q1=8'h77 with SRAM_WR_BYPASS_EN,
//     8'h00 without.
//  5. reset_n low for 1 cycle mid-CLEAR (counter=5) -> clear restarts at 0, full 8-cycle busy, clr_done once.
//  6. cen0=1 during busy writing 8'hFF @2 -> ignored, rvalid0=0; @2 reads CLEAR_VALUE after done.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the byte-lane dual-port RAM: clear-FSM encodings and lane helpers.
// Pure declarations; no clocked logic, no latency, no flow control.
package sram_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Widest word / lane count the merge helper handles.
  localparam int MAX_W = 256;
  localparam int MAX_L = 256;

  function automatic int lanes(input int data_width, input int lane_width);
    return data_width / lane_width;
  endfunction

  function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] old_w,
                                             input logic [MAX_W-1:0] new_w,
                                             input logic [MAX_L-1:0] be,
                                             input int               lane_width);
    logic [MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_W; i++) begin
      if (be[8'(i / lane_width)]) res[8'(i)] = new_w[8'(i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_dual_sync_be_if.sv
// Bus bundle for sram_dual_sync_be: clear control/status plus two independent access ports.
// master drives requests and write data; slave returns read data, valid strobes and status.
interface sram_dual_sync_be_if
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LANE_WIDTH = 8
);
  localparam int LANES = lanes(DATA_WIDTH, LANE_WIDTH);

  logic                  clr_req;
  logic                  busy;
  logic                  clr_done;
  logic                  wr_coll;

  logic                  cen0;
  logic                  we0;
  logic [LANES-1:0]      be0;
  logic [ADDR_WIDTH-1:0] ADDR0;
  logic [DATA_WIDTH-1:0] DATA0;
  logic [DATA_WIDTH-1:0] Q0;
  logic                  rvalid0;

  logic                  cen1;
  logic                  we1;
  logic [LANES-1:0]      be1;
  logic [ADDR_WIDTH-1:0] ADDR1;
  logic [DATA_WIDTH-1:0] DATA1;
  logic [DATA_WIDTH-1:0] Q1;
  logic                  rvalid1;

  modport master (
    output clr_req, cen0, we0, be0, ADDR0, DATA0, cen1, we1, be1, ADDR1, DATA1,
    input  busy, clr_done, wr_coll, Q0, rvalid0, Q1, rvalid1
  );

  modport slave (
    input  clr_req, cen0, we0, be0, ADDR0, DATA0, cen1, we1, be1, ADDR1, DATA1,
    output busy, clr_done, wr_coll, Q0, rvalid0, Q1, rvalid1
  );

endinterface

// File: rtl/sram_clear_seq.sv
// Clear sequencer: walks word pairs {cnt,0}/{cnt,1}, busy for 2**(ADDR_WIDTH-1) cycles then a 1-cycle done.
// clr_req only honoured in IDLE; no backpressure, requests while busy or done are dropped.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_req_i,
  output logic                  busy_o,
  output logic                  clr_done_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);
  localparam int            CW       = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((2 ** (ADDR_WIDTH - 1)) - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = (state_q == ST_CLEAR);
  assign clr_done_o = (state_q == ST_DONE);
  // Even word of the pair; the odd partner is formed by the top level.
  assign clr_addr_o = ADDR_WIDTH'({cnt_q, 1'b0});

endmodule

// File: rtl/sram_dual_sync_be.sv
// True dual-port byte-lane RAM with port-0-priority collisions, clear sequencer, RD_LATENCY 1/2 output stage.
// No stalls: one access per port per cycle; SRAM_WR_BYPASS_EN selects write-first instead of read-first.
module sram_dual_sync_be
  import sram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 10,
  parameter int                    LANE_WIDTH     = 8,
  parameter int                    RD_LATENCY     = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic               clk,
  input logic               reset_n,
  sram_dual_sync_be_if.slave bus
);
  localparam int LANES = lanes(DATA_WIDTH, LANE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] merge_w(input logic [DATA_WIDTH-1:0] o,
                                                    input logic [DATA_WIDTH-1:0] n,
                                                    input logic [LANES-1:0]      b);
    return DATA_WIDTH'(merge(MAX_W'(o), MAX_W'(n), MAX_L'(b), LANE_WIDTH));
  endfunction

  logic                  busy;
  logic                  clr_done;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_req_i  (bus.clr_req),
    .busy_o     (busy),
    .clr_done_o (clr_done),
    .clr_addr_o (clr_addr)
  );

  logic [1:0]            acc, wr, w_en;
  logic                  coll;
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [ADDR_WIDTH-1:0] w_addr [2];
  logic [DATA_WIDTH-1:0] wdat   [2];
  logic [DATA_WIDTH-1:0] w_dat  [2];
  logic [LANES-1:0]      be     [2];
  logic [LANES-1:0]      w_be   [2];
  logic [DATA_WIDTH-1:0] rd_d   [2];

  assign addr[0] = bus.ADDR0;
  assign addr[1] = bus.ADDR1;
  assign wdat[0] = bus.DATA0;
  assign wdat[1] = bus.DATA1;
  assign be[0]   = bus.be0;
  assign be[1]   = bus.be1;
  assign acc     = {bus.cen1, bus.cen0} & {2{~busy}};
  assign wr      = acc & {bus.we1, bus.we0};
  assign coll    = wr[0] & wr[1] & (addr[0] == addr[1]);

  // While clearing, both write ports are taken over by the sequencer.
  always_comb begin
    w_en = {wr[1] & ~coll, wr[0]};
    for (int p = 0; p < 2; p++) begin
      w_addr[p] = addr[p];
      w_dat[p]  = wdat[p];
      w_be[p]   = be[p];
    end
    if (busy) begin
      w_en      = 2'b11;
      w_addr[0] = clr_addr;
      w_addr[1] = clr_addr | ADDR_WIDTH'(1);
      for (int p = 0; p < 2; p++) begin
        w_dat[p] = CLEAR_VALUE;
        w_be[p]  = '1;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en[1]) mem_q[w_addr[1]] <= merge_w(mem_q[w_addr[1]], w_dat[1], w_be[1]);
    if (w_en[0]) mem_q[w_addr[0]] <= merge_w(mem_q[w_addr[0]], w_dat[0], w_be[0]);
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_d[p] = mem_q[addr[p]];
`ifdef SRAM_WR_BYPASS_EN
      // Port 1 applied first so port 0 overrides, matching the array result.
      if (w_en[1] && (w_addr[1] == addr[p])) rd_d[p] = merge_w(rd_d[p], w_dat[1], w_be[1]);
      if (w_en[0] && (w_addr[0] == addr[p])) rd_d[p] = merge_w(rd_d[p], w_dat[0], w_be[0]);
`endif
    end
  end

  logic [1:0]            s1_vld_q;
  logic [DATA_WIDTH-1:0] s1_dat_q [2];
  logic                  wr_coll_q;
  logic [1:0]            q_vld;
  logic [DATA_WIDTH-1:0] q_dat [2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_q    <= '0;
      s1_dat_q[0] <= '0;
      s1_dat_q[1] <= '0;
      wr_coll_q   <= 1'b0;
    end else begin
      s1_vld_q  <= acc;
      wr_coll_q <= coll;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) s1_dat_q[p] <= rd_d[p];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [1:0]            s2_vld_q;
      logic [DATA_WIDTH-1:0] s2_dat_q [2];

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          s2_vld_q    <= '0;
          s2_dat_q[0] <= '0;
          s2_dat_q[1] <= '0;
        end else begin
          s2_vld_q <= s1_vld_q;
          for (int p = 0; p < 2; p++) begin
            if (s1_vld_q[p]) s2_dat_q[p] <= s1_dat_q[p];
          end
        end
      end

      assign q_vld    = s2_vld_q;
      assign q_dat[0] = s2_dat_q[0];
      assign q_dat[1] = s2_dat_q[1];
    end else begin : g_lat1
      assign q_vld    = s1_vld_q;
      assign q_dat[0] = s1_dat_q[0];
      assign q_dat[1] = s1_dat_q[1];
    end
  endgenerate

  assign bus.busy     = busy;
  assign bus.clr_done = clr_done;
  assign bus.wr_coll  = wr_coll_q;
  assign bus.Q0       = q_dat[0];
  assign bus.Q1       = q_dat[1];
  assign bus.rvalid0  = q_vld[0];
  assign bus.rvalid1  = q_vld[1];

endmodule

// File: tb/tb_sram_dual_sync_be.sv
// Bench for sram_dual_sync_be (16-bit words, 2 lanes, 16 words, clear value 16'h00A5).
// A word-level model is checked every cycle, plus directed literal expectations.
module tb_sram_dual_sync_be;
  localparam int          RD_LAT = 1;
  localparam logic [15:0] CV     = 16'h00A5;
`ifdef SRAM_WR_BYPASS_EN
  localparam logic [15:0] RDW_EXP = 16'h0077;
`else
  localparam logic [15:0] RDW_EXP = 16'h0000;
`endif

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  int   done_seen;
  int   n;
  bit   chk_en;
  logic [15:0] q;

  sram_dual_sync_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8)) bus ();

  sram_dual_sync_be #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .LANE_WIDTH(8), .RD_LATENCY(RD_LAT),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [15:0] mm [16];
  bit          m_clearing, m_done, m_coll;
  logic [2:0]  m_cnt;
  logic [15:0] m_q0, m_q1;
  bit          m_v0, m_v1;
  bit          s_v0, s_v1, o_v0, o_v1, t_a0, t_a1, t_w0, t_w1, t_coll, t_last;
  logic [15:0] s_d0, s_d1, o_d0, o_d1, t_r0, t_r1;

  function automatic logic [15:0] mrg(input logic [15:0] o, input logic [15:0] d, input logic [1:0] b);
    logic [15:0] r;
    r = o;
    if (b[0]) r[7:0] = d[7:0];
    if (b[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_clearing = 1; m_cnt = 0; m_done = 0; m_coll = 0;
      m_q0 = 0; m_q1 = 0; m_v0 = 0; m_v1 = 0; s_v0 = 0; s_v1 = 0;
    end else begin
      if (m_clearing) begin
        mm[{m_cnt, 1'b0}] = CV;
        mm[{m_cnt, 1'b1}] = CV;
        t_last = (m_cnt == 3'd7);
        m_cnt = m_cnt + 3'd1;
        m_clearing = !t_last;
        m_done = t_last;
        m_coll = 0;
        t_a0 = 0; t_a1 = 0; t_r0 = 0; t_r1 = 0;
      end else begin
        t_a0 = bus.cen0; t_a1 = bus.cen1;
        t_w0 = t_a0 && bus.we0; t_w1 = t_a1 && bus.we1;
        t_coll = t_w0 && t_w1 && (bus.ADDR0 == bus.ADDR1);
        t_r0 = mm[bus.ADDR0]; t_r1 = mm[bus.ADDR1];
        if (t_w1 && !t_coll) mm[bus.ADDR1] = mrg(mm[bus.ADDR1], bus.DATA1, bus.be1);
        if (t_w0) mm[bus.ADDR0] = mrg(mm[bus.ADDR0], bus.DATA0, bus.be0);
`ifdef SRAM_WR_BYPASS_EN
        t_r0 = mm[bus.ADDR0]; t_r1 = mm[bus.ADDR1];
`endif
        m_coll = t_coll;
        if (bus.clr_req && !m_done) begin m_clearing = 1; m_cnt = 0; end
        m_done = 0;
      end
      if (RD_LAT == 2) begin
        o_v0 = s_v0; o_d0 = s_d0; s_v0 = t_a0; s_d0 = t_r0;
        o_v1 = s_v1; o_d1 = s_d1; s_v1 = t_a1; s_d1 = t_r1;
      end else begin
        o_v0 = t_a0; o_d0 = t_r0; o_v1 = t_a1; o_d1 = t_r1;
      end
      m_v0 = o_v0; if (o_v0) m_q0 = o_d0;
      m_v1 = o_v1; if (o_v1) m_q1 = o_d1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(bus.busy), 32'(m_clearing));
      chk("clr_done", 32'(bus.clr_done), 32'(m_done));
      chk("wr_coll", 32'(bus.wr_coll), 32'(m_coll));
      chk("rvalid0", 32'(bus.rvalid0), 32'(m_v0));
      chk("rvalid1", 32'(bus.rvalid1), 32'(m_v1));
      chk("q0", 32'(bus.Q0), 32'(m_q0));
      chk("q1", 32'(bus.Q1), 32'(m_q1));
      if (bus.clr_done) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input int p, input bit cen, input bit we, input logic [1:0] b,
                     input logic [3:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.cen0 = cen; bus.we0 = we; bus.be0 = b; bus.ADDR0 = a; bus.DATA0 = d;
    end else begin
      bus.cen1 = cen; bus.we1 = we; bus.be1 = b; bus.ADDR1 = a; bus.DATA1 = d;
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, 2'b00, 4'h0, 16'h0);
    drv(1, 0, 0, 2'b00, 4'h0, 16'h0);
  endtask

  task automatic wrp(input int p, input logic [1:0] b, input logic [3:0] a, input logic [15:0] d);
    drv(p, 1, 1, b, a, d);
    tick();
    idle();
  endtask

  task automatic rdp(input int p, input logic [3:0] a, output logic [15:0] r);
    drv(p, 1, 0, 2'b00, a, 16'h0);
    tick();
    idle();
    repeat (RD_LAT - 1) tick();
    chk("rvalid_latency", 32'((p == 0) ? bus.rvalid0 : bus.rvalid1), 32'd1);
    r = (p == 0) ? bus.Q0 : bus.Q1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; done_seen = 0; chk_en = 0;
    reset_n = 1'b0; bus.clr_req = 1'b0;
    idle();
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_q0", 32'(bus.Q0), 32'd0);
    chk("rst_coll", 32'(bus.wr_coll), 32'd0);

    // Power-on clear
    chk_en = 1; reset_n = 1'b1; done_seen = 0; n = 0;
    while (bus.busy && n < 50) begin tick(); n++; end
    chk("clr_cycles", 32'(n), 32'd8);
    chk("clr_done_pulse", 32'(bus.clr_done), 32'd1);
    tick();
    chk("clr_done_end", 32'(bus.clr_done), 32'd0);
    chk("clr_done_count", 32'(done_seen), 32'd1);
    for (int i = 0; i < 16; i++) begin
      rdp(i % 2, 4'(i), q);
      chk("clr_word", 32'(q), 32'(CV));
    end

    // Lane merge
    wrp(0, 2'b11, 4'd3, 16'h1234);
    wrp(0, 2'b01, 4'd3, 16'hABCD);
    rdp(0, 4'd3, q);
    chk("lane_merge0", 32'(q), 32'h12CD);
    wrp(1, 2'b10, 4'd7, 16'hBEEF);
    rdp(1, 4'd7, q);
    chk("lane_merge1", 32'(q), 32'hBEA5);
    wrp(0, 2'b00, 4'd7, 16'h1111);
    rdp(0, 4'd7, q);
    chk("be_zero_noop", 32'(q), 32'hBEA5);

    // Collision: port 0 wins
    drv(0, 1, 1, 2'b11, 4'd5, 16'h0011);
    drv(1, 1, 1, 2'b11, 4'd5, 16'h0022);
    tick(); idle();
    chk("coll_pulse", 32'(bus.wr_coll), 32'd1);
    tick();
    chk("coll_end", 32'(bus.wr_coll), 32'd0);
    rdp(1, 4'd5, q);
    chk("coll_word", 32'(q), 32'h0011);

    // Simultaneous writes to different words
    drv(0, 1, 1, 2'b11, 4'd6, 16'h6666);
    drv(1, 1, 1, 2'b11, 4'd8, 16'h8888);
    tick(); idle();
    chk("no_coll", 32'(bus.wr_coll), 32'd0);
    rdp(0, 4'd8, q);
    chk("dual_wr8", 32'(q), 32'h8888);
    rdp(1, 4'd6, q);
    chk("dual_wr6", 32'(q), 32'h6666);

    // Read-during-write across ports
    wrp(0, 2'b11, 4'd9, 16'h0000);
    drv(0, 1, 1, 2'b11, 4'd9, 16'h0077);
    drv(1, 1, 0, 2'b00, 4'd9, 16'h0);
    tick(); idle();
    repeat (RD_LAT - 1) tick();
    chk("rdw_q1", 32'(bus.Q1), 32'(RDW_EXP));
    rdp(1, 4'd9, q);
    chk("rdw_after", 32'(q), 32'h0077);

    // Requested clear, interrupted by reset mid-way
    wrp(0, 2'b11, 4'd12, 16'h5555);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    chk("req_busy", 32'(bus.busy), 32'd1);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; done_seen = 0;
    drv(0, 1, 1, 2'b11, 4'd2, 16'h00FF);
    tick(); idle();
    chk("busy_rvalid0", 32'(bus.rvalid0), 32'd0);
    n = 1;
    while (bus.busy && n < 50) begin tick(); n++; end
    chk("restart_cycles", 32'(n), 32'd8);
    tick();
    chk("restart_done_count", 32'(done_seen), 32'd1);
    rdp(0, 4'd2, q);
    chk("busy_wr_ignored", 32'(q), 32'(CV));
    rdp(1, 4'd12, q);
    chk("recleared12", 32'(q), 32'(CV));
    rdp(0, 4'd3, q);
    chk("recleared3", 32'(q), 32'(CV));

    tick();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
